// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and constants used by the fetch stage and its
// pipeline registers.
package cpu_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge channel between the fetch stage
// (master) and instruction memory (slave).
interface if_fetch_stage_if;

    logic                       imem_req;
    logic [cpu_pkg::INST_W-1:0] imem_addr;
    logic                       imem_ack;
    logic [cpu_pkg::INST_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);

    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_id_reg.sv
// Pipeline register with bubble/load/hold controls; bubble wins over load,
// and a bubble keeps the previous pc4 so only the valid bit and word change.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP = NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_bubble,
    input  logic [INST_W-1:0] i_inst,
    input  logic [INST_W-1:0] i_pc4,
    output logic              o_valid,
    output logic [INST_W-1:0] o_inst,
    output logic [INST_W-1:0] o_pc4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_inst  <= NOP;
            o_pc4   <= '0;
        end else if (i_bubble) begin
            o_valid <= 1'b0;
            o_inst  <= NOP;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_inst  <= i_inst;
            o_pc4   <= i_pc4;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, variable-latency imem handshake, IF/ID register.
// Optional build macro FETCH_PERF_CNT_EN adds saturating bubble/flush counters.
module if_fetch_stage #(
    parameter logic [cpu_pkg::INST_W-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [cpu_pkg::INST_W-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       PCWrite,
    input  logic                       IFIDWrite,
    input  logic                       flush,
    input  logic                       redirect_valid,
    input  logic [cpu_pkg::INST_W-1:0] redirect_pc,
    if_fetch_stage_if.master           imem,
    output logic                       if_id_valid,
    output logic [cpu_pkg::INST_W-1:0] if_id_inst,
    output logic [cpu_pkg::INST_W-1:0] if_id_pc4,
    output logic                       fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                perf_bubble_cnt,
    output logic [31:0]                perf_flush_cnt
`endif
);

    import cpu_pkg::*;

    localparam logic [INST_W-1:0] ALIGN_MASK = ~INST_W'(3);
    localparam logic [INST_W-1:0] PC_STEP    = INST_W'(4);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [INST_W-1:0] r_pc;
    logic [INST_W-1:0] r_hold_inst;
    logic [INST_W-1:0] r_req_addr;
    logic              r_req;
    logic [INST_W-1:0] w_pc_nxt;
    logic [INST_W-1:0] w_target;
    logic [INST_W-1:0] w_ld_inst;
    logic              w_kill;
    logic              w_adv;
    logic              w_ld;
    logic              w_bub;

    assign w_kill   = flush | redirect_valid;
    assign w_adv    = PCWrite & IFIDWrite;
    assign w_target = redirect_valid ? (redirect_pc & ALIGN_MASK) : r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= BOOT;
        else      r_state <= w_state_nxt;
    end

    // Next state, PC and IF/ID controls; flush/redirect override everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ld        = 1'b0;
        w_bub       = 1'b0;
        w_ld_inst   = r_hold_inst;
        case (r_state)
            BOOT: begin
                w_state_nxt = FETCH;
                w_bub       = IFIDWrite;
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    w_ld_inst = imem.imem_rdata;
                    if (w_adv) begin
                        w_ld     = 1'b1;
                        w_pc_nxt = r_pc + PC_STEP;
                    end else begin
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_bub = IFIDWrite;
                end
            end
            HOLD: begin
                if (w_adv) begin
                    w_ld        = 1'b1;
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_state_nxt = FETCH;
                end
            end
            DRAIN: begin
                w_bub = IFIDWrite;
                if (imem.imem_ack) w_state_nxt = FETCH;
            end
            default: w_state_nxt = BOOT;
        endcase
        if (w_kill) begin
            w_ld     = 1'b0;
            w_bub    = 1'b1;
            w_pc_nxt = w_target;
            // An unanswered request must still complete at its old address.
            if ((r_state == FETCH || r_state == DRAIN) && !imem.imem_ack)
                w_state_nxt = DRAIN;
            else
                w_state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_hold_inst <= NOP_INST;
            r_req       <= 1'b0;
            r_req_addr  <= RESET_PC;
        end else begin
            r_pc  <= w_pc_nxt;
            r_req <= (w_state_nxt == FETCH) || (w_state_nxt == DRAIN);
            if (r_state == FETCH && imem.imem_ack && !w_adv)
                r_hold_inst <= imem.imem_rdata;
            if (w_state_nxt == FETCH)
                r_req_addr <= w_pc_nxt;
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_req_addr;
    assign fetch_busy     = (r_state == FETCH || r_state == DRAIN) && !imem.imem_ack;

    if_id_reg #(
        .NOP      (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst),
        .i_load   (w_ld),
        .i_bubble (w_bub),
        .i_inst   (w_ld_inst),
        .i_pc4    (r_pc + PC_STEP),
        .o_valid  (if_id_valid),
        .o_inst   (if_id_inst),
        .o_pc4    (if_id_pc4)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_bub && !w_kill && r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_kill && r_flush_cnt != '1)            r_flush_cnt  <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized scoreboard bench for if_fetch_stage: expected instruction stream
// is kept as a program-order queue of {inst, pc+4} computed from the PC rules.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCWrite = 1'b1;
    logic        IFIDWrite = 1'b1;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    if_fetch_stage_if imem ();

    if_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .if_id_valid    (if_id_valid),
        .if_id_inst     (if_id_inst),
        .if_id_pc4      (if_id_pc4),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt(perf_bubble_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   delivered = 0;
    int   lat_max  = 0;
    logic stim_en  = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] next_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    function automatic void refill();
        exp_t e;
        while (exp_q.size() < 4) begin
            e.inst  = mem_word(next_pc);
            e.pc4   = next_pc + 32'd4;
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        refill();
    endfunction

    // Inputs seen by the DUT at each rising edge.
    logic e_rst = 1'b0, e_fresh = 1'b0, e_kill = 1'b0;
    always @(posedge clk) begin
        e_rst   = rst;
        e_fresh = IFIDWrite | flush | redirect_valid;
        e_kill  = flush | redirect_valid;
    end

    // Monitor: compares IF/ID against the scoreboard after each edge.
    logic        last_valid;
    logic [31:0] last_inst, last_pc4;
    always @(negedge clk) begin
        exp_t e;
        if (!e_rst) begin
            check("rst_valid", {31'd0, if_id_valid}, 32'd0);
            check("rst_inst", if_id_inst, 32'd0);
            check("rst_pc4", if_id_pc4, 32'd0);
        end else if (e_fresh) begin
            if (e_kill) check("kill_valid", {31'd0, if_id_valid}, 32'd0);
            if (if_id_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_inst", if_id_inst, e.inst);
                    check("ifid_pc4", if_id_pc4, e.pc4);
                    delivered++;
                end
            end else begin
                check("bubble_inst", if_id_inst, 32'd0);
            end
        end else begin
            check("hold_valid", {31'd0, if_id_valid}, {31'd0, last_valid});
            check("hold_inst", if_id_inst, last_inst);
            check("hold_pc4", if_id_pc4, last_pc4);
        end
        last_valid = if_id_valid;
        last_inst  = if_id_inst;
        last_pc4   = if_id_pc4;
    end

    // Random hazard/redirect stimulus; the model restarts at each redirect target.
    initial begin
        int          r;
        logic [31:0] tgt;
        forever begin
            @(negedge clk);
            #1;
            if (stim_en) begin
                r = int'($urandom_range(0, 99));
                if (r < 70)      begin PCWrite = 1'b1; IFIDWrite = 1'b1; end
                else if (r < 85) begin PCWrite = 1'b0; IFIDWrite = 1'b0; end
                else             begin PCWrite = 1'b1; IFIDWrite = 1'b0; end
                flush          = ($urandom_range(0, 19) == 0);
                redirect_valid = ($urandom_range(0, 15) == 0);
                if (redirect_valid) begin
                    if ($urandom_range(0, 2) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                    else                           tgt = $urandom;
                    redirect_pc = tgt;
                    restart(tgt & 32'hFFFF_FFFC);
                end
            end else begin
                PCWrite = 1'b1; IFIDWrite = 1'b1; flush = 1'b0; redirect_valid = 1'b0;
            end
            refill();
        end
    end

    // Instruction memory with random latency; also checks handshake stability.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          waited, lat;
        pend = 1'b0; waited = 0; lat = 0; pend_addr = '0;
        imem.imem_ack = 1'b0;
        imem.imem_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pend = 1'b0;
                imem.imem_ack = 1'b0;
            end else begin
                if (pend) begin
                    check("req_held", {31'd0, imem.imem_req}, 32'd1);
                    check("addr_stable", imem.imem_addr, pend_addr);
                end
                if (imem.imem_req) begin
                    if (!pend) begin
                        pend = 1'b1; pend_addr = imem.imem_addr; waited = 0;
                        lat = int'($urandom_range(0, lat_max));
                    end
                    imem.imem_ack   = (waited >= lat);
                    imem.imem_rdata = imem.imem_ack ? mem_word(imem.imem_addr) : $urandom;
                    waited++;
                    if (imem.imem_ack) pend = 1'b0;
                end else begin
                    imem.imem_ack   = 1'($urandom_range(0, 1));
                    imem.imem_rdata = $urandom;
                end
            end
            #1;
            check("fetch_busy", {31'd0, fetch_busy}, {31'd0, imem.imem_req & ~imem.imem_ack});
        end
    end

    // Release reset just after an edge so BOOT lasts one full cycle, then check 1/cycle fetch.
    task automatic release_and_boot();
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("boot_req", {31'd0, imem.imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem.imem_req}, 32'd1);
        check("first_addr", imem.imem_addr, RST_PC);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("throughput", {31'd0, if_id_valid}, 32'd1);
        end
    endtask

    initial begin
        logic found;
        restart(RST_PC);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem.imem_req}, 32'd0);
        release_and_boot();

        lat_max = 3;
        stim_en = 1'b1;
        repeat (1500) @(negedge clk);

        stim_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            #3;
            if (imem.imem_req && !imem.imem_ack) found = 1'b1;
        end
        check("midreq_found", {31'd0, found}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_req", {31'd0, imem.imem_req}, 32'd0);
        check("async_valid", {31'd0, if_id_valid}, 32'd0);
        check("async_inst", if_id_inst, 32'd0);
        check("async_pc4", if_id_pc4, 32'd0);
        restart(RST_PC);
        lat_max = 0;
        repeat (2) @(negedge clk);
        release_and_boot();

        lat_max = 3;
        stim_en = 1'b1;
        repeat (1500) @(negedge clk);
        stim_en = 1'b0;
        repeat (10) @(negedge clk);
        check("delivered_min", {31'd0, delivered >= 300}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory req/ack handshake, and IF/ID pipeline register.
- Sits directly upstream of the ID-stage hazard detection unit and consumes its PCWrite / IFIDWrite / flush controls.
- Accepts branch/jump redirects from ID and presents {valid, inst, pc+4} to ID.
- Tolerates variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word placed in IF/ID on a bubble or flush.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- PCWrite  in  1  hazard unit: 1 = PC may advance.
- IFIDWrite  in  1  hazard unit: 1 = IF/ID may load.
- flush  in  1  hazard unit: squash IF/ID contents and in-flight fetch.
- redirect_valid  in  1  branch taken / jump resolved in ID.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and no ack.
- imem_ack  in  1  read data valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word, sampled when imem_ack=1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  IF/ID instruction.
- if_id_pc4  out  32  IF/ID PC+4.
- fetch_busy  out  1  1 while in FETCH or DRAIN with no ack this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=BOOT; imem_req=0.
  - if_id_valid=0; if_id_inst=NOP_INST; if_id_pc4=0.
  - Applies mid-request: the outstanding request is abandoned; memory must tolerate a dropped req.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: one cycle after reset release, then FETCH. imem_req=0.
- FETCH: imem_req=1, imem_addr=pc.
  - Ack with advance enabled (PCWrite & IFIDWrite & ~flush & ~redirect_valid):
    - IF/ID <= {1, imem_rdata, pc+4}; pc <= pc+4; stay FETCH.
    - Next request issues the following cycle, giving 1 instruction/cycle with a 1-cycle ack.
  - Ack with advance blocked by PCWrite=0 or IFIDWrite=0: hold_inst <= imem_rdata; go to HOLD.
  - No ack and IFIDWrite=1: IF/ID <= bubble {0, NOP_INST, unchanged pc4}.
  - No ack and IFIDWrite=0: IF/ID holds.
- HOLD: imem_req=0.
  - When PCWrite & IFIDWrite: IF/ID <= {1, hold_inst, pc+4}; pc <= pc+4; go to FETCH.
  - Otherwise remain in HOLD; IF/ID and pc unchanged.
- flush or redirect_valid (highest priority, evaluated every cycle, overrides IFIDWrite=0):
  - IF/ID <= bubble.
  - If redirect_valid: pc <= {redirect_pc[31:2], 2'b00}; otherwise pc unchanged.
  - In HOLD: the held word is discarded; go to FETCH.
  - In FETCH with ack this cycle: the response is discarded; go to FETCH at the new pc.
  - In FETCH without ack: go to DRAIN; imem_addr keeps the old pc until ack (handshake rule).
- DRAIN: imem_req=1 at the old address; the ack is discarded; then FETCH at the redirected pc.
  - A redirect arriving during DRAIN overwrites the pending target (latest wins).
  - pc register holds the target; the old address is kept in req_addr.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- PCWrite=1 with IFIDWrite=0 is treated as blocked: pc never advances without the instruction entering IF/ID.
- No combinational path from imem_rdata to any output except via registers.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_bubble_cnt counts cycles IF/ID loads a bubble for a reason other than flush/redirect.
  - perf_flush_cnt counts cycles with flush | redirect_valid.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - fetch_state_t enum: BOOT=2'd0, FETCH=2'd1, HOLD=2'd2, DRAIN=2'd3.
  - RESET_PC_DEFAULT and NOP_INST constants.
  - Instruction width constant INST_W=32.
- One sub-module, if_id_reg: IF/ID register with load, bubble, and hold controls.
  - Asynchronous active-low reset.
  - Reusable pattern for id_ex_reg.

Test Plan:
- Reset release, 1-cycle ack, rdata = 0x20080001, 0x20090002 → imem_addr 0x3000, 0x3004; IF/ID valid with pc4 0x3004, then 0x3008; throughput 1/cycle.
- Ack at 0x3008 while PCWrite=IFIDWrite=0 for 2 cycles (load-use) → HOLD, imem_req=0, IF/ID unchanged; on release, IF/ID = held word, pc4=0x300C.
- 3-cycle ack latency at 0x3010 with redirect_valid=1, redirect_pc=0x3403 in cycle 1 → imem_addr stays 0x3010 until ack; ack discarded; next req at 0x3400; IF/ID bubble throughout.
- flush=1 in HOLD → held word dropped, IF/ID valid=0 inst=0, next req at the unchanged pc.
- Redirect to 0xFFFF_FFFC then straight-line → next fetch address 0x0000_0000 (wrap).
- rst=0 asserted mid-request (req high, no ack) → outputs reset immediately; after release, BOOT for 1 cycle, then req at 0x3000.
